// File: rtl/imem_program_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Holds the FSM state encoding and the word-geometry helpers.
package imem_loader_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned MEM_BYTES_DEFAULT = 192;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLen0  = 3'd1,
    StLen1  = 3'd2,
    StData  = 3'd3,
    StWrite = 3'd4,
    StDone  = 3'd5
  } loader_state_e;

  function automatic int unsigned max_words(input int unsigned mem_bytes);
    return mem_bytes / WORD_BYTES;
  endfunction

endpackage

// File: rtl/imem_program_loader_if.sv
// Byte-stream input and instruction-memory word write port of the loader.
// master: byte source / memory side; slave: the loader itself.
interface imem_program_loader_if;

  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

endinterface

// File: rtl/imem_program_loader_byte_packer.sv
// Packs four consecutive accepted bytes into a little-endian 32-bit word.
// word_o already includes the byte being accepted this cycle.
module imem_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  logic [1:0]  idx_q;
  logic [31:0] word_q;
  logic [31:0] word_d;

  always_comb begin
    word_d = word_q;
    word_d[{idx_q, 3'b000} +: 8] = byte_i;
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      idx_q  <= 2'd0;
      word_q <= 32'h0;
    end else if (byte_valid_i) begin
      idx_q  <= idx_q + 2'd1;
      word_q <= word_d;
    end
  end

  assign word_o      = word_d;
  assign word_full_o = byte_valid_i && (idx_q == 2'd3);

endmodule

// File: rtl/imem_program_loader.sv
// Boot-time loader: length-prefixed byte stream to instruction memory words.
// Holds the CPU in reset until a complete, legal program has been written.
module imem_program_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  imem_program_loader_if.slave bus_if,
  output logic                 cpu_hold_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [CNT_W-1:0]     words_loaded_o
);

  localparam int unsigned MaxWords = max_words(MEM_BYTES);

  loader_state_e    state_q;
  logic [15:0]      len_q;
  logic [CNT_W-1:0] words_q;
  logic             in_ready_q;
  logic             mem_we_q;
  logic [31:0]      mem_addr_q;
  logic [31:0]      mem_wdata_q;
  logic             cpu_hold_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic             xfer;
  logic             pack_valid;
  logic             pack_clear;
  logic [31:0]      pack_word;
  logic             pack_full;
  logic [15:0]      len_full;
  logic [CNT_W-1:0] words_inc;

  assign xfer       = bus_if.in_valid && in_ready_q;
  assign pack_valid = xfer && (state_q == StData);
  // A new load always starts from an empty packer, whatever was left behind.
  assign pack_clear = start_i && ((state_q == StIdle) || (state_q == StDone));
  assign len_full   = {bus_if.in_data, len_q[7:0]};
  assign words_inc  = words_q + CNT_W'(1);

  imem_byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (pack_clear),
    .byte_valid_i (pack_valid),
    .byte_i       (bus_if.in_data),
    .word_o       (pack_word),
    .word_full_o  (pack_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      len_q       <= 16'h0;
      words_q     <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      cpu_hold_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            state_q    <= StLen0;
            words_q    <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            cpu_hold_q <= 1'b1;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
          end
        end
        StLen0: begin
          if (xfer) begin
            len_q[7:0] <= bus_if.in_data;
            state_q    <= StLen1;
          end
        end
        StLen1: begin
          if (xfer) begin
            len_q[15:8] <= bus_if.in_data;
            if (len_full == 16'h0) begin
              state_q    <= StDone;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else if (32'(len_full) > MaxWords) begin
              // Oversize header: finish without writing and keep the CPU held.
              state_q    <= StDone;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              err_q      <= 1'b1;
            end else begin
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (xfer && pack_full) begin
            state_q     <= StWrite;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= BASE_ADDR + 32'(words_q) * WORD_BYTES;
            mem_wdata_q <= pack_word;
          end
        end
        StWrite: begin
          words_q <= words_inc;
          if (32'(words_inc) == 32'(len_q)) begin
            state_q    <= StDone;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            cpu_hold_q <= 1'b0;
          end else begin
            state_q    <= StData;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= StIdle;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus_if.in_ready  = in_ready_q;
  assign bus_if.mem_we    = mem_we_q;
  assign bus_if.mem_addr  = mem_addr_q;
  assign bus_if.mem_wdata = mem_wdata_q;
  assign cpu_hold_o       = cpu_hold_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign err_o            = err_q;
  assign words_loaded_o   = words_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader: reset, single word, full memory,
// oversize header, zero length with restart, and reset in the middle of a word.
module tb_imem_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          ready_viol = 0;

  imem_program_loader_if bus ();

  imem_program_loader #(
    .MEM_BYTES (192),
    .BASE_ADDR (32'h0),
    .CNT_W     (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start),
    .bus_if         (bus),
    .cpu_hold_o     (cpu_hold),
    .busy_o         (busy),
    .done_o         (done),
    .err_o          (err),
    .words_loaded_o (words_loaded)
  );

  always #5 clk = ~clk;

  // Write-port monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
      if (bus.in_ready !== 1'b0) ready_viol++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    ready_viol = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int  n = 0;
    logic accepted = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!accepted && n < 200) begin
      accepted = bus.in_ready;
      tick();
      n++;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h5A;
    checks++;
    if (!accepted) begin
      errors++;
      $display("FAIL byte_accept: byte %02h not accepted, in_ready stayed 0", b);
    end
  endtask

  task automatic send_len(input logic [15:0] n);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout: done=%b, required 1", name, done);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 5) & 255);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks += 6;
    if (cpu_hold !== 1'b1) begin errors++; $display("FAIL rst_cpu_hold: %b, required 1", cpu_hold); end
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: %b, required 0", bus.in_ready); end
    if (done !== 1'b0) begin errors++; $display("FAIL rst_done: %b, required 0", done); end
    if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: %b, required 0", bus.mem_we); end
    if (words_loaded !== 16'd0) begin errors++; $display("FAIL rst_words: %0d, required 0", words_loaded); end
    if (busy !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL rst_busy_err: busy=%b err=%b, required 0 0", busy, err);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_word();
    clear_log();
    pulse_start();
    checks++;
    if (busy !== 1'b1 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL sw_busy: busy=%b in_ready=%b, required 1 1", busy, bus.in_ready);
    end
    send_len(16'd1);
    pulse_start();  // ignored in DATA
    send_byte(8'h14);
    send_byte(8'h00);
    send_byte(8'hA0);
    send_byte(8'hE3);
    wait_done("sw");
    checks += 4;
    if (wr_addr.size() != 1) begin
      errors++; $display("FAIL sw_write_count: %0d writes, required 1", wr_addr.size());
    end else if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'hE3A00014) begin
      errors++;
      $display("FAIL sw_write: addr=%08h data=%08h, required 00000000 E3A00014",
               wr_addr[0], wr_data[0]);
    end
    if (cpu_hold !== 1'b0) begin errors++; $display("FAIL sw_cpu_hold: %b, required 0", cpu_hold); end
    if (words_loaded !== 16'd1) begin errors++; $display("FAIL sw_words: %0d, required 1", words_loaded); end
    if (busy !== 1'b0) begin errors++; $display("FAIL sw_busy_end: %b, required 0", busy); end
  endtask

  task automatic test_full_memory();
    logic [31:0] exp;
    clear_log();
    pulse_start();
    send_len(16'd48);
    for (int i = 0; i < 192; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      send_byte(pat(i));
    end
    wait_done("full");
    checks++;
    if (wr_addr.size() != 48) begin
      errors++; $display("FAIL full_write_count: %0d writes, required 48", wr_addr.size());
    end
    for (int w = 0; w < 48 && w < wr_addr.size(); w++) begin
      exp = {pat(4 * w + 3), pat(4 * w + 2), pat(4 * w + 1), pat(4 * w)};
      checks++;
      if (wr_addr[w] !== 32'(4 * w) || wr_data[w] !== exp) begin
        errors++;
        $display("FAIL full_write_%0d: addr=%08h data=%08h, required %08h %08h",
                 w, wr_addr[w], wr_data[w], 32'(4 * w), exp);
      end
    end
    checks += 4;
    if (ready_viol != 0) begin
      errors++; $display("FAIL full_ready_in_write: %0d cycles, required 0", ready_viol);
    end
    if (words_loaded !== 16'd48) begin errors++; $display("FAIL full_words: %0d, required 48", words_loaded); end
    if (cpu_hold !== 1'b0) begin errors++; $display("FAIL full_cpu_hold: %b, required 0", cpu_hold); end
    if (err !== 1'b0) begin errors++; $display("FAIL full_err: %b, required 0", err); end
  endtask

  task automatic test_oversize();
    clear_log();
    pulse_start();
    send_len(16'd49);
    tick();
    tick();
    checks += 5;
    if (err !== 1'b1) begin errors++; $display("FAIL ovs_err: %b, required 1", err); end
    if (done !== 1'b1) begin errors++; $display("FAIL ovs_done: %b, required 1", done); end
    if (cpu_hold !== 1'b1) begin errors++; $display("FAIL ovs_cpu_hold: %b, required 1", cpu_hold); end
    if (wr_addr.size() != 0) begin errors++; $display("FAIL ovs_writes: %0d, required 0", wr_addr.size()); end
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL ovs_in_ready: %b, required 0", bus.in_ready); end
    pulse_start();
    checks += 2;
    if (err !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL ovs_restart_clear: err=%b done=%b, required 0 0", err, done);
    end
    if (cpu_hold !== 1'b1 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ovs_restart_state: cpu_hold=%b in_ready=%b, required 1 1", cpu_hold, bus.in_ready);
    end
  endtask

  // Continues the load started at the end of test_oversize.
  task automatic test_zero_and_restart();
    clear_log();
    send_len(16'd0);
    checks += 3;
    if (done !== 1'b1) begin errors++; $display("FAIL zero_done: %b, required 1", done); end
    if (cpu_hold !== 1'b0) begin errors++; $display("FAIL zero_cpu_hold: %b, required 0", cpu_hold); end
    if (words_loaded !== 16'd0) begin errors++; $display("FAIL zero_words: %0d, required 0", words_loaded); end
    tick();
    checks++;
    if (wr_addr.size() != 0) begin errors++; $display("FAIL zero_writes: %0d, required 0", wr_addr.size()); end
    pulse_start();
    checks++;
    if (done !== 1'b0 || cpu_hold !== 1'b1) begin
      errors++; $display("FAIL rs_start: done=%b cpu_hold=%b, required 0 1", done, cpu_hold);
    end
    send_len(16'd2);
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    wait_done("rs");
    checks += 2;
    if (wr_addr.size() != 2) begin
      errors++; $display("FAIL rs_write_count: %0d writes, required 2", wr_addr.size());
    end else begin
      if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h04030201) begin
        errors++;
        $display("FAIL rs_write_0: addr=%08h data=%08h, required 00000000 04030201",
                 wr_addr[0], wr_data[0]);
      end
      if (wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h08070605) begin
        errors++;
        $display("FAIL rs_write_1: addr=%08h data=%08h, required 00000004 08070605",
                 wr_addr[1], wr_data[1]);
      end
    end
    checks++;
    if (words_loaded !== 16'd2) begin errors++; $display("FAIL rs_words: %0d, required 2", words_loaded); end
  endtask

  task automatic test_reset_mid_word();
    clear_log();
    pulse_start();
    send_len(16'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks += 3;
    if (bus.in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_rst_state: in_ready=%b busy=%b, required 0 0", bus.in_ready, busy);
    end
    if (cpu_hold !== 1'b1) begin errors++; $display("FAIL mid_rst_cpu_hold: %b, required 1", cpu_hold); end
    if (words_loaded !== 16'd0) begin errors++; $display("FAIL mid_rst_words: %0d, required 0", words_loaded); end
    tick();
    tick();
    checks++;
    if (wr_addr.size() != 0) begin errors++; $display("FAIL mid_rst_writes: %0d, required 0", wr_addr.size()); end
    pulse_start();
    send_len(16'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    wait_done("mid");
    checks++;
    if (wr_addr.size() != 1) begin
      errors++; $display("FAIL mid_write_count: %0d writes, required 1", wr_addr.size());
    end else if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h44332211) begin
      errors++;
      $display("FAIL mid_write: addr=%08h data=%08h, required 00000000 44332211",
               wr_addr[0], wr_data[0]);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
    test_single_word();
    test_full_memory();
    test_oversize();
    test_zero_and_restart();
    test_reset_mid_word();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
